hssim_select: RTL

Parametrised per-pixel winner selector for the HSSIM fusion back-end. It generalises the two-map old/new HSSIM decision to NUM_CAND candidate maps. For each lane it receives one signed numerator/denominator pair per candidate and resolves the best ratio with a pipelined pairwise tournament. It emits the winning candidate index and an 8-bit selection mask for the downstream Gaussian blur. Flow control is valid/ready in place of a global stall.

---
 rtl/hssim_select.sv | 106 ++++++++++
 1 files changed

// File: rtl/hssim_select.sv
// hssim_select: per-lane NUM_CAND-way N/D ratio tournament with valid/ready flow and post-reset blanking.
// Define HSSIM_SEL_TIE_HIGH_EN to let the higher index win exact ratio ties.
module hssim_select #(
  parameter int PIXELS_PER_BEAT = 16,
  parameter int NUM_CAND = 4,
  parameter int NUM_W = 36,
  parameter int BLANK_BEATS = 6,
  localparam int IDX_W = (NUM_CAND > 2) ? $clog2(NUM_CAND) : 1
) (
  input  logic                                     clk,
  input  logic                                     aresetn,
  input  logic                                     valid_in,
  output logic                                     ready_in,
  input  logic [NUM_CAND*PIXELS_PER_BEAT*NUM_W-1:0] numr_in,
  input  logic [NUM_CAND*PIXELS_PER_BEAT*NUM_W-1:0] denr_in,
  output logic                                     valid_out,
  input  logic                                     ready_out,
  output logic [IDX_W*PIXELS_PER_BEAT-1:0]          idx_out,
  output logic [8*PIXELS_PER_BEAT-1:0]              mask_out
);
  localparam int L = $clog2(NUM_CAND);
  localparam int S = 2 * L;
  localparam int PW = 2 * NUM_W;
  localparam int CNT_W = (BLANK_BEATS > 0) ? $clog2(BLANK_BEATS + 1) : 1;
  typedef struct packed {
    logic [NUM_W-1:0] n;
    logic [NUM_W-1:0] d;
    logic [IDX_W-1:0] idx;
    logic             inv;
  } ent_t;
  function automatic int width_at(int l);
    return (NUM_CAND + (1 << l) - 1) >> l;
  endfunction
  logic             adv;
  logic [S-1:0]     vld_q, vld_d, blk_q, blk_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    adv = ~(valid_out & ~ready_out);
    cnt_d = (valid_in & adv & (cnt_q != '0)) ? cnt_q - CNT_W'(1) : cnt_q;
    vld_d = adv ? {vld_q[S-2:0], valid_in} : vld_q;
    blk_d = adv ? {blk_q[S-2:0], cnt_q != '0} : blk_q;
  end
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      vld_q <= '0;
      blk_q <= '0;
      cnt_q <= CNT_W'(BLANK_BEATS);
    end else begin
      vld_q <= vld_d;
      blk_q <= blk_d;
      cnt_q <= cnt_d;
    end
  end
  assign ready_in = adv;
  assign valid_out = vld_q[S-1];
  for (genvar j = 0; j < PIXELS_PER_BEAT; j++) begin : g_lane
    ent_t             lvl [L+1][NUM_CAND];
    logic [IDX_W-1:0] idx;
    for (genvar k = 0; k < NUM_CAND; k++) begin : g_in
      localparam int O = (k * PIXELS_PER_BEAT + j) * NUM_W;
      assign lvl[0][k] = {numr_in[O +: NUM_W], denr_in[O +: NUM_W], IDX_W'(k), denr_in[O +: NUM_W] == '0};
    end
    for (genvar l = 0; l < L; l++) begin : g_lvl
      for (genvar i = 0; i < NUM_CAND; i++) begin : g_m
        if (i < width_at(l + 1)) begin : g_match
          ent_t                 a, b, ea_q, ea_d, eb_q, eb_d, w_q, w_d;
          logic signed [PW-1:0] pa_q, pa_d, pb_q, pb_d;
          logic                 gt, b_win;
          assign a = lvl[l][2*i];
          // An unpaired entry meets a permanently invalid opponent, so it simply rides the registers.
          if (2 * i + 1 < width_at(l)) begin : g_b
            assign b = lvl[l][2*i+1];
          end else begin : g_bye
            assign b = '{n: '0, d: '0, idx: '0, inv: 1'b1};
          end
          always_comb begin
            pa_d = adv ? PW'($signed(a.n)) * PW'($signed(b.d)) : pa_q;
            pb_d = adv ? PW'($signed(b.n)) * PW'($signed(a.d)) : pb_q;
            ea_d = adv ? a : ea_q;
            eb_d = adv ? b : eb_q;
            gt = (pb_q != pa_q) & ((pb_q > pa_q) ^ (ea_q.d[NUM_W-1] ^ eb_q.d[NUM_W-1]));
`ifdef HSSIM_SEL_TIE_HIGH_EN
            b_win = ~eb_q.inv & (ea_q.inv | gt | (pb_q == pa_q));
`else
            b_win = ~eb_q.inv & (ea_q.inv | gt);
`endif
            w_d = adv ? (b_win ? eb_q : ea_q) : w_q;
          end
          always_ff @(posedge clk) begin
            pa_q <= pa_d;
            pb_q <= pb_d;
            ea_q <= ea_d;
            eb_q <= eb_d;
            w_q <= w_d;
          end
          assign lvl[l+1][i] = w_q;
        end else begin : g_none
          assign lvl[l+1][i] = '0;
        end
      end
    end
    assign idx = (valid_out & ~blk_q[S-1] & ~lvl[L][0].inv) ? lvl[L][0].idx : '0;
    assign idx_out[j*IDX_W +: IDX_W] = idx;
    assign mask_out[j*8 +: 8] = (idx != '0) ? 8'hFF : 8'h00;
  end
endmodule
